// File: rtl/table_loader.sv
// Write-side controller for the three coefficient tables: takes a valid/ready word
// stream and writes one entry of n_words words into each table in turn.
module table_loader #(
    parameter int n_words     = 40,
    parameter int max_entries = 819
) (
    input  logic        clk,
    input  logic        ctrl_reset_n,
    input  logic [26:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [1:0]  command,
    output logic [26:0] tdatai,
    output logic [14:0] twraddr,
    output logic [2:0]  twren,
    output logic [9:0]  entry_count,
    output logic        full,
    output logic        idle,
    output logic        done
);
    localparam int wc_w = $clog2(n_words);
    localparam logic [wc_w-1:0] wc_last   = wc_w'(n_words - 1);
    localparam logic [wc_w-1:0] wc_one    = wc_w'(1);
    localparam logic [14:0]     base_step = 15'(n_words);
    localparam logic [9:0]      entry_max = 10'(max_entries);

    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_RESET = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOAD = 1'b1} state_t;

    state_t          state_r;
    logic [14:0]     base_r;
    logic [wc_w-1:0] wcount_r;
    logic [1:0]      tsel_r;
    logic [9:0]      entry_count_r;
    logic [26:0]     tdatai_r;
    logic [14:0]     twraddr_r;
    logic [2:0]      twren_r;
    logic            done_r;

    logic            full_s;
    logic            ready_s;
    logic            xfer_s;
    logic            last_word_s;

    // Handshake and status decode; ABORT always blocks the transfer in its cycle.
    always_comb begin
        full_s      = (entry_count_r == entry_max);
        ready_s     = (state_r == ST_LOAD) && (command != CMD_ABORT);
        xfer_s      = ready_s && din_valid;
        last_word_s = (wcount_r == wc_last);
    end

    // Load sequencer with registered table write port.
    always_ff @(posedge clk) begin
        if (!ctrl_reset_n) begin
            state_r       <= ST_IDLE;
            base_r        <= 15'd0;
            wcount_r      <= '0;
            tsel_r        <= 2'd0;
            entry_count_r <= 10'd0;
            tdatai_r      <= 27'd0;
            twraddr_r     <= 15'd0;
            twren_r       <= 3'b000;
            done_r        <= 1'b0;
        end else begin
            twren_r <= 3'b000;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (command == CMD_START && !full_s) begin
                        wcount_r <= '0;
                        tsel_r   <= 2'd0;
                        state_r  <= ST_LOAD;
                    end else if (command == CMD_RESET) begin
                        base_r        <= 15'd0;
                        entry_count_r <= 10'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (command == CMD_ABORT) begin
                        wcount_r <= '0;
                        tsel_r   <= 2'd0;
                        state_r  <= ST_IDLE;
                    end else if (xfer_s) begin
                        tdatai_r  <= din;
                        twraddr_r <= base_r + 15'(wcount_r);
                        twren_r   <= 3'b001 << tsel_r;
                        if (last_word_s) begin
                            wcount_r <= '0;
                            if (tsel_r == 2'd2) begin
                                // Last word of table 2 closes the entry.
                                tsel_r        <= 2'd0;
                                base_r        <= base_r + base_step;
                                entry_count_r <= entry_count_r + 10'd1;
                                done_r        <= 1'b1;
                                state_r       <= ST_IDLE;
                            end else begin
                                tsel_r <= tsel_r + 2'd1;
                            end
                        end else begin
                            wcount_r <= wcount_r + wc_one;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign din_ready   = ready_s;
    assign tdatai      = tdatai_r;
    assign twraddr     = twraddr_r;
    assign twren       = twren_r;
    assign entry_count = entry_count_r;
    assign full        = full_s;
    assign idle        = (state_r == ST_IDLE);
    assign done        = done_r;
endmodule

// File: doc/table_loader.md
Name: table_loader

Overview:
- Write-side controller for the three coefficient tables.
- Accepts a valid/ready stream of 27-bit words from the host dispatch path and writes them into the tables at sequential addresses, one table at a time.
- Drives the tables' shared write data and write address, plus one one-hot write enable per table.
- Each completed load adds one entry of n_words words to every table, so the stream-out controller can read entries at base addresses 0, n_words, 2·n_words, and so on.

Parameters:
- n_words, 40, words per table per entry; must be ≥ 2.
- max_entries, 819, number of entries the 15-bit address space holds; n_words·max_entries must be ≤ 32768.

Ports:
- clk  in  1  clock.
- ctrl_reset_n  in  1  reset; synchronous, active-low.
- din  in  27  input word.
- din_valid  in  1  din is valid.
- din_ready  out  1  loader accepts din this cycle.
- command  in  2  01=START, 10=RESET, 11=ABORT, 00=none.
- tdatai  out  27  table write data.
- twraddr  out  15  table write address.
- twren  out  3  one-hot table write enable, bit i selects table i.
- entry_count  out  10  number of completed entries.
- full  out  1  entry_count == max_entries.
- idle  out  1  state is ST_IDLE.
- done  out  1  one-cycle pulse when an entry completes.

Behaviour:
- Reset:
  - Sampled on the clk edge while ctrl_reset_n=0.
  - All registers clear: state=ST_IDLE, base=0, wcount=0, tsel=0, entry_count=0.
  - Outputs: tdatai=0, twraddr=0, twren=000, done=0, din_ready=0, idle=1, full=0.
  - Reset mid-load discards the partial entry; no write enable may fire in the cycle after reset.
- State ST_IDLE:
  - din_ready=0.
  - START with full=0: wcount=0, tsel=0, go to ST_LOAD.
  - START with full=1: ignored; stay in ST_IDLE.
  - RESET: base=0, entry_count=0. Table contents are untouched; they are overwritten by later loads.
  - ABORT or none: no effect.
- State ST_LOAD:
  - din_ready=1. A transfer occurs when din_valid & din_ready.
  - On a transfer, the next cycle presents tdatai=din, twraddr=base+wcount and twren=(1<<tsel), for exactly one cycle.
  - Outside that cycle twren=000; tdatai and twraddr hold their last values.
  - Counter update on a transfer:
    - If wcount==n_words-1: wcount=0 and tsel increments.
    - Otherwise wcount increments.
  - Entry completion: on the transfer with tsel==2 and wcount==n_words-1:
    - base += n_words and entry_count += 1.
    - done=1 in the next cycle, coincident with the final twren=100.
    - Return to ST_IDLE.
  - din_valid=0: hold all counters; no write is issued.
  - ABORT:
    - Return to ST_IDLE with wcount=0 and tsel=0; base and entry_count are unchanged.
    - A transfer in the same cycle is not accepted: din_ready is forced to 0 whenever command==ABORT.
  - START or RESET while in ST_LOAD: ignored.
- Widths and ordering:
  - twraddr = base + zero-extended wcount, 15 bits; base is always ≤ n_words·(max_entries−1).
  - full and idle are combinational from registers; din_ready is combinational from state and command.
  - Words arrive in table-major order: table0 words 0..n-1, then table1, then table2.

Test Plan:
- n_words=4, reset, START, 12 words 0x1..0xC with din_valid held high:
  - twren sequence is 001×4, 010×4, 100×4.
  - twraddr is 0,1,2,3 repeated for each table.
  - done pulses with the 12th write; entry_count=1; idle=1.
- Second START plus 12 more words:
  - twraddr is 4..7 for each table and entry_count=2.
  - Then RESET in idle, START plus 12 words: twraddr returns to 0..3.
- din_valid toggled 1,0,1,0 during a load:
  - Exactly one write per accepted word.
  - twraddr has no gaps or duplicates.
  - No twren pulse in the cycles with no transfer.
- ABORT after 6 words:
  - idle=1 and entry_count unchanged.
  - The next START rewrites from twraddr=base with twren=001.
  - din_ready=0 in the ABORT cycle, so the concurrent word is not written.
- max_entries=2, n_words=4:
  - After 2 loads, full=1 and START leaves idle=1 with din_ready=0.
  - RESET clears full.
- ctrl_reset_n low mid-load after word 5:
  - Next cycle: twren=000, entry_count=0, idle=1.
  - A new load then starts at twraddr=0.
